// File: rtl/inv_sub_bytes.sv
// Iterative AES InvSubBytes engine: substitutes BYTES_PER_CYCLE bytes of a latched
// 128-bit state per clock, then holds the result until the downstream stage takes it.
module inv_sub_bytes #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
    localparam int CW     = 8 * BYTES_PER_CYCLE;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("inv_sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero without special casing
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    // Inverse affine transform first, then field inversion
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] s;
        s = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return gf_inv(s);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       src_q, src_d;
    logic [127:0]       res_q, res_d;
    logic [CW-1:0]      src_chunk;
    logic [CW-1:0]      sub_chunk;

    always_comb begin
        src_chunk = src_q[127 - int'(cnt_q) * CW -: CW];
        sub_chunk = '0;
        for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
            sub_chunk[CW-1-8*j -: 8] = inv_sbox(src_chunk[CW-1-8*j -: 8]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        res_d   = res_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                res_d[127 - int'(cnt_q) * CW -: CW] = sub_chunk;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Source copy is only meaningful after an accept, so it needs no reset
    always_ff @(posedge clk) begin
        src_q <= src_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign out_data  = res_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Bench for inv_sub_bytes: five instances (1,2,4,8,16 bytes/cycle) checked every cycle
// against a timing/value model built from forward S-box arithmetic.
module tb_inv_sub_bytes;

    localparam int NL = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst  [NL];
    logic         iv   [NL];
    logic         ird  [NL];
    logic [127:0] idat [NL];
    logic         ov   [NL];
    logic         ordy [NL];
    logic [127:0] odat [NL];
    logic         bsy  [NL];

    generate
        for (genvar g = 0; g < NL; g++) begin : g_dut
            inv_sub_bytes #(.BYTES_PER_CYCLE(1 << g)) u_dut (
                .clk      (clk),
                .reset    (rst[g]),
                .in_valid (iv[g]),
                .in_ready (ird[g]),
                .in_data  (idat[g]),
                .out_valid(ov[g]),
                .out_ready(ordy[g]),
                .out_data (odat[g]),
                .busy     (bsy[g])
            );
        end
    endgenerate

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;

    logic [7:0]   fwd     [256];
    logic [7:0]   inv_tab [256];
    bit           pend    [NL];
    bit           zero    [NL];
    int           tacc    [NL];
    logic [127:0] expd    [NL];
    int           done_cnt[NL];
    bit           m_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s lane%0d @cyc%0d: got %h, expected %h", nm, k, cyc, act, expv);
        end
    endtask

    // Carry-less product reduced by the AES polynomial 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [127:0] inv128(input logic [127:0] v);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[127-8*j -: 8] = inv_tab[v[127-8*j -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Per-cycle compare, then advance the model with the inputs the next edge will see
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            m_ev = pend[k] && (cyc >= tacc[k] + (16 >> k));
            if (chk_en) begin
                chk("in_ready", k, 128'(ird[k]), 128'(!pend[k]));
                chk("out_valid", k, 128'(ov[k]), 128'(m_ev));
                chk("busy", k, 128'(bsy[k]), 128'(pend[k] && !m_ev));
                if (m_ev) chk("out_data", k, odat[k], expd[k]);
                else if (zero[k]) chk("out_data_rst", k, odat[k], '0);
            end
            if (rst[k]) begin
                pend[k] = 1'b0;
                zero[k] = 1'b1;
            end else if (!pend[k] && iv[k]) begin
                pend[k] = 1'b1;
                zero[k] = 1'b0;
                tacc[k] = cyc + 1;
                expd[k] = inv128(idat[k]);
            end else if (m_ev && ordy[k]) begin
                pend[k] = 1'b0;
                done_cnt[k]++;
            end
        end
    end

    task automatic send(input int k, input logic [127:0] d, output int acc);
        acc = -1;
        @(posedge clk); #1;
        iv[k] = 1'b1;
        idat[k] = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ird[k] === 1'b1) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) chk("accept_timeout", k, 128'(0), 128'(1));
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, output int t);
        t = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ov[k] === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk("valid_timeout", k, 128'(0), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, c0;
        logic [127:0] d, known_out;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] b, y;
            b = 8'h00;
            for (int c = 1; c < 256; c++) if (gmul(8'(x), 8'(c)) == 8'h01) b = 8'(c);
            y = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd[x] = y;
            inv_tab[y] = 8'(x);
        end
        chk("pin_sbox00", -1, 128'(fwd[8'h00]), 128'(8'h63));
        chk("pin_sbox53", -1, 128'(fwd[8'h53]), 128'(8'hed));
        chk("pin_inv63", -1, 128'(inv_tab[8'h63]), 128'(8'h00));
        chk("pin_inv7c", -1, 128'(inv_tab[8'h7c]), 128'(8'h01));
        chk("pin_inv00", -1, 128'(inv_tab[8'h00]), 128'(8'h52));
        chk("pin_inv16", -1, 128'(inv_tab[8'h16]), 128'(8'hff));
        chk("pin_invfe", -1, 128'(inv_tab[8'hfe]), 128'(8'h0c));
        chk("pin_inv52", -1, 128'(inv_tab[8'h52]), 128'(8'h48));

        for (int k = 0; k < NL; k++) begin
            rst[k] = 1'b1; iv[k] = 1'b0; ordy[k] = 1'b1; idat[k] = '0;
            pend[k] = 1'b0; zero[k] = 1'b1; tacc[k] = 0; expd[k] = '0; done_cnt[k] = 0;
        end
        iv[0] = 1'b1;
        idat[0] = rnd128();

        // Reset for two edges with in_valid high: nothing may be accepted
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 0, 128'(ird[0]), 128'(1));
        chk("rst_out_valid", 0, 128'(ov[0]), 128'(0));
        chk("rst_busy", 0, 128'(bsy[0]), 128'(0));
        chk("rst_out_data", 0, odat[0], '0);
        for (int k = 0; k < NL; k++) rst[k] = 1'b0;
        iv[0] = 1'b0;

        // Known bytes with backpressure, 1 byte/cycle
        known_out = 128'h000152ff0c5300000000000000000000;
        ordy[0] = 1'b0;
        send(0, 128'h637c0016feed63636363636363636363, acc);
        wait_valid(0, t);
        chk("latency", 0, 128'(t - acc), 128'(16));
        chk("known_data", 0, odat[0], known_out);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            iv[0] = (i % 2 == 1);
            idat[0] = rnd128();
            @(negedge clk);
            chk("hold_valid", 0, 128'(ov[0]), 128'(1));
            chk("hold_in_ready", 0, 128'(ird[0]), 128'(0));
            chk("hold_data", 0, odat[0], known_out);
        end
        @(posedge clk); #1;
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("release_valid", 0, 128'(ov[0]), 128'(1));
        @(negedge clk);
        chk("after_xfer_ready", 0, 128'(ird[0]), 128'(1));
        chk("after_xfer_valid", 0, 128'(ov[0]), 128'(0));

        // All 256 byte values through the 4 bytes/cycle instance
        for (int s = 0; s < 16; s++) begin
            for (int j = 0; j < 16; j++) d[127-8*j -: 8] = 8'(s * 16 + j);
            send(2, d, acc);
            wait_valid(2, t);
            chk("latency", 2, 128'(t - acc), 128'(4));
            for (int j = 0; j < 16; j++)
                chk("sbox_roundtrip", 2, 128'(fwd[odat[2][127-8*j -: 8]]), 128'(d[127-8*j -: 8]));
        end

        // Reset in the third BUSY cycle, 2 bytes/cycle
        send(1, rnd128(), acc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        chk("midrst_idle", 1, 128'(ird[1]), 128'(1));
        chk("midrst_busy", 1, 128'(bsy[1]), 128'(0));
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("midrst_no_emit", 1, 128'(ov[1]), 128'(0));
        end
        send(1, {16{8'h52}}, acc);
        wait_valid(1, t);
        chk("latency", 1, 128'(t - acc), 128'(8));
        chk("all52", 1, odat[1], {16{8'h48}});

        // Full-width instance: single cycle, then saturated traffic
        send(4, '0, acc);
        wait_valid(4, t);
        chk("latency", 4, 128'(t - acc), 128'(1));
        chk("all00", 4, odat[4], {16{8'h52}});
        @(posedge clk); #1;
        iv[4] = 1'b1;
        idat[4] = rnd128();
        c0 = done_cnt[4];
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            idat[4] = rnd128();
        end
        chk("b2b_rate", 4, 128'(done_cnt[4] - c0), 128'(10));
        iv[4] = 1'b0;

        // Random traffic on every instance, occasional resets
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            for (int k = 0; k < NL; k++) begin
                iv[k]   = ($urandom % 2) == 0;
                ordy[k] = ($urandom % 4) != 0;
                rst[k]  = ($urandom % 64) == 0;
                idat[k] = rnd128();
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NL; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; rst[k] = 1'b0;
        end
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) chk("drained", k, 128'(ird[k]), 128'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
